// File: rtl/seq_sched_pkg.sv
// Shared types for the serial 1010 detector scheduler.
//   state_t      : scheduler sequencing states
//   core_state_t : Moore detector states, A = nothing matched ... E = "1010" seen
//   PAT_LEN      : length of the detected pattern
package seq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH,
    RESP
  } state_t;

  typedef enum logic [2:0] {
    CORE_A,
    CORE_B,
    CORE_C,
    CORE_D,
    CORE_E
  } core_state_t;

  localparam int PAT_LEN = 4;

endpackage

// File: rtl/moore_1010_core.sv
// Bit-serial Moore detector for the pattern 1010 with overlap.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, returns to A
//   clr : synchronous clear, returns to A (takes priority over x)
//   x   : serial input bit
//   z   : 1 while in state E (last four bits were 1010)
module moore_1010_core
  import seq_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic x,
  output logic z
);

  core_state_t st, st_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= CORE_A;
    end else if (clr) begin
      st <= CORE_A;
    end else begin
      st <= st_nxt;
    end
  end

  // On a 1 after "1010" the suffix "101" is kept, which gives overlapping matches.
  always_comb begin
    st_nxt = st;
    unique case (st)
      CORE_A:  st_nxt = x ? CORE_B : CORE_A;
      CORE_B:  st_nxt = x ? CORE_B : CORE_C;
      CORE_C:  st_nxt = x ? CORE_D : CORE_A;
      CORE_D:  st_nxt = x ? CORE_B : CORE_E;
      CORE_E:  st_nxt = x ? CORE_D : CORE_A;
      default: st_nxt = CORE_A;
    endcase
  end

  assign z = (st == CORE_E);

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one serial 1010 detector among N_REQ requesters.
// A granted word is shifted MSB-first into the core; overlapping matches are counted
// and returned with the requester id in a one-cycle response.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : per-requester word valid
//   req_data   : requester i word at [i*WORD_W +: WORD_W]
//   req_ready  : one-hot accept pulse, only in IDLE
//   resp_valid : one-cycle result pulse
//   resp_id    : requester owning the result (held until next response)
//   resp_count : overlapping match count (held)
//   resp_hit   : resp_count != 0 (held)
//   busy       : high outside IDLE
module seq_det_scheduler
  import seq_sched_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int WORD_W = 16,
  parameter  int CNT_W  = $clog2(WORD_W) + 1,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*WORD_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_id,
  output logic [CNT_W-1:0]        resp_count,
  output logic                    resp_hit,
  output logic                    busy
);

  localparam int BC_W = $clog2(WORD_W + 1);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   grant_id;
  logic              grant_vld;
  logic              accept;
  logic [ID_W-1:0]   cur_id;
  logic [WORD_W-1:0] shreg;
  logic [BC_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]  match_cnt;
  logic [CNT_W-1:0]  final_cnt;
  logic              count_en;
  logic              core_x;
  logic              core_z;

  // Round-robin arbitration: first valid requester at or after ptr, wrapping.
  always_comb begin : arb
    int idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  assign accept    = (state == IDLE) && grant_vld;
  assign req_ready = accept ? (N_REQ'(1) << grant_id) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ptr     <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        bit_cnt <= bit_cnt + BC_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_vld) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == BC_W'(WORD_W - 1)) state_nxt = FLUSH;
      FLUSH:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accept stage: capture word and id; shift stage feeds the core MSB-first.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg  <= req_data[int'(grant_id)*WORD_W +: WORD_W];
      cur_id <= grant_id;
    end else if (state == SHIFT) begin
      shreg <= shreg << 1;
    end
  end

  assign core_x = (state == SHIFT) ? shreg[WORD_W-1] : 1'b0;

  moore_1010_core u_core (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .x   (core_x),
    .z   (core_z)
  );

  // Count stage: z lags the input by one cycle, so the first SHIFT cycle never
  // contributes and FLUSH picks up the result of the last bit.
  assign count_en  = ((state == SHIFT) && (bit_cnt != '0)) || (state == FLUSH);
  assign final_cnt = match_cnt + CNT_W'(core_z);

  always_ff @(posedge clk) begin
    if (accept) begin
      match_cnt <= '0;
    end else if (count_en && core_z) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

  // Response stage: result registered on the FLUSH->RESP edge and held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_id    <= '0;
      resp_count <= '0;
      resp_hit   <= 1'b0;
    end else if (state == FLUSH) begin
      resp_id    <= cur_id;
      resp_count <= final_cnt;
      resp_hit   <= (final_cnt != '0);
    end
  end

  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

endmodule
